alu_muldiv_ctrl: RTL and testbench

- Sequencer that owns the shared combinational ALU's multiply (S=4'b0011) and divide (S=4'b0100) paths.
- These paths are closed as multicycle timing paths. The controller holds the ALU opcode and operands stable for a programmable number of cycles, then captures R/R2 into architectural LO/HI registers.
- Sits beside the execute stage: the pipeline issues mult/div/mthi/mtlo requests through a valid/ready handshake and stalls on busy.

---
 rtl/alu_muldiv_pkg.sv | 21 ++
 rtl/alu_muldiv_timer.sv | 32 +++
 rtl/alu_muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the multicycle multiply/divide sequencer: ALU opcodes,
// request encodings and controller states.
package alu_muldiv_pkg;

    localparam logic [3:0] ALU_S_MUL  = 4'b0011;
    localparam logic [3:0] ALU_S_DIV  = 4'b0100;
    localparam logic [3:0] ALU_S_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } req_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_muldiv_timer.sv
// Loadable 4-bit down counter that times how long the ALU inputs are held.
module alu_muldiv_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// Sequencer for the shared ALU's multicycle MUL/DIV paths; captures R/R2 into LO/HI.
// Optional divide-by-zero trap (div0 output) enabled by ALU_MULDIV_DIV0_TRAP_EN.
module alu_muldiv_ctrl
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic [3:0]  alu_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_r,
    input  logic [31:0] alu_r2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
`ifdef ALU_MULDIV_DIV0_TRAP_EN
    ,
    output logic        div0
`endif
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [3:0]  s_q, s_d;
    logic        done_q, done_d, div0_q, div0_d;
    logic        accept, t_load, t_dec, t_zero;
    logic [3:0]  t_load_val;

    assign req_ready = (state_q == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        done_d     = 1'b0;
        div0_d     = 1'b0;
        t_load     = 1'b0;
        t_load_val = MUL_LOAD;
        t_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (req_op_e'(req_op))
                        OP_MUL: begin
                            a_d     = req_a;
                            b_d     = req_b;
                            s_d     = ALU_S_MUL;
                            t_load  = 1'b1;
                            state_d = RUN;
                        end
                        OP_DIV: begin
`ifdef ALU_MULDIV_DIV0_TRAP_EN
                            if (req_b == 32'd0) begin
                                done_d = 1'b1;
                                div0_d = 1'b1;
                            end else
`endif
                            begin
                                a_d        = req_a;
                                b_d        = req_b;
                                s_d        = ALU_S_DIV;
                                t_load     = 1'b1;
                                t_load_val = DIV_LOAD;
                                state_d    = RUN;
                            end
                        end
                        OP_MTHI: hi_d = req_a;
                        OP_MTLO: lo_d = req_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Flush beats a coinciding capture edge.
                if (flush) begin
                    s_d     = ALU_S_IDLE;
                    state_d = IDLE;
                end else if (t_zero) begin
                    lo_d    = alu_r;
                    hi_d    = alu_r2;
                    s_d     = ALU_S_IDLE;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            s_q     <= ALU_S_IDLE;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    alu_muldiv_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_load_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_s = s_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
`ifdef ALU_MULDIV_DIV0_TRAP_EN
    assign div0  = div0_q;
`else
    logic unused_div0;
    assign unused_div0 = div0_q;
`endif

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Randomized and directed bench for alu_muldiv_ctrl against a transaction-level model.
module tb_alu_muldiv_ctrl;

    localparam int MUL_N = 2;
    localparam int DIV_N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'd0, req_b = 32'd0;
    logic        req_ready, flush = 1'b0;
    logic [3:0]  alu_s;
    logic [31:0] alu_a, alu_b, alu_r, alu_r2, hi, lo;
    logic        busy, done;
`ifdef ALU_MULDIV_DIV0_TRAP_EN
    logic        div0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .flush     (flush),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_r     (alu_r),
        .alu_r2    (alu_r2),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
`ifdef ALU_MULDIV_DIV0_TRAP_EN
        ,
        .div0      (div0)
`endif
    );

    // Combinational ALU stand-in; divide-by-zero yields all-ones quotient, remainder = a.
    always_comb begin
        logic [63:0] p;
        p      = 64'(alu_a) * 64'(alu_b);
        alu_r  = 32'd0;
        alu_r2 = 32'd0;
        if (alu_s == 4'b0011) begin
            alu_r  = p[31:0];
            alu_r2 = p[63:32];
        end else if (alu_s == 4'b0100) begin
            if (alu_b == 32'd0) begin
                alu_r  = 32'hFFFF_FFFF;
                alu_r2 = alu_a;
            end else begin
                alu_r  = alu_a / alu_b;
                alu_r2 = alu_a % alu_b;
            end
        end
    end

    // Transaction-level model: remaining edges until capture and the precomputed result.
    bit          m_busy, m_done, m_div0;
    int          m_rem;
    logic [31:0] m_hi, m_lo, m_a, m_b, res_hi, res_lo;
    logic [3:0]  m_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_div0 = 0; m_rem = 0;
            m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_s = 4'hF;
        end else begin
            m_done = 0;
            m_div0 = 0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 0;
                    m_s = 4'hF;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_hi = res_hi; m_lo = res_lo;
                        m_busy = 0; m_done = 1; m_s = 4'hF;
                    end
                end
            end else if (req_valid && !flush) begin
                case (req_op)
                    2'b00: begin
                        {res_hi, res_lo} = 64'(req_a) * 64'(req_b);
                        m_a = req_a; m_b = req_b; m_s = 4'h3;
                        m_busy = 1; m_rem = MUL_N;
                    end
                    2'b01: begin
`ifdef ALU_MULDIV_DIV0_TRAP_EN
                        if (req_b == 0) begin
                            m_done = 1; m_div0 = 1;
                        end else
`endif
                        begin
                            if (req_b == 0) begin
                                res_lo = 32'hFFFF_FFFF; res_hi = req_a;
                            end else begin
                                res_lo = req_a / req_b; res_hi = req_a % req_b;
                            end
                            m_a = req_a; m_b = req_b; m_s = 4'h4;
                            m_busy = 1; m_rem = DIV_N;
                        end
                    end
                    2'b10: m_hi = req_a;
                    default: m_lo = req_a;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req_ready", 64'(req_ready), 64'(!m_busy && !flush));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
        chk("alu_s", 64'(alu_s), 64'(m_s));
        chk("alu_a", 64'(alu_a), 64'(m_a));
        chk("alu_b", 64'(alu_b), 64'(m_b));
`ifdef ALU_MULDIV_DIV0_TRAP_EN
        chk("div0", 64'(div0), 64'(m_div0));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        cyc();
        req_valid = 1'b0;
    endtask

    // Runs until the model is idle; returns DUT busy cycles seen. Bounded.
    task automatic wait_idle(output int nbusy);
        int n;
        n = busy ? 1 : 0;
        for (int i = 0; i < 40 && m_busy; i++) begin
            cyc();
            if (busy) n++;
        end
        if (m_busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: timed out, busy=%0b expected idle", busy);
        end
        nbusy = n;
    endtask

    initial begin
        int nb;
        rst = 1'b1;
        #1;
        chk("reset_alu_s", 64'(alu_s), 64'hF);
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        #20;
        rst = 1'b0;
        cyc();

        // MUL FFFFFFFF * 2
        issue(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_idle(nb);
        chk("mul_busy_cycles", 64'(nb), 64'd2);
        chk("mul_done", 64'(done), 64'd1);
        chk("mul_hi", 64'(hi), 64'h1);
        chk("mul_lo", 64'(lo), 64'hFFFF_FFFE);

        // DIV 100 / 7
        issue(2'b01, 32'd100, 32'd7);
        wait_idle(nb);
        chk("div_busy_cycles", 64'(nb), 64'd8);
        chk("div_lo", 64'(lo), 64'd14);
        chk("div_hi", 64'(hi), 64'd2);
        cyc();
        chk("div_done_once", 64'(done), 64'd0);

        // MTHI / MTLO back to back
        issue(2'b10, 32'hDEAD_BEEF, 32'd0);
        chk("mthi", 64'(hi), 64'hDEAD_BEEF);
        chk("mthi_busy", 64'(busy | done), 64'd0);
        issue(2'b11, 32'h1234_5678, 32'd0);
        chk("mtlo", 64'(lo), 64'h1234_5678);
        chk("mtlo_busy", 64'(busy | done), 64'd0);

        // DIV flushed in 4th RUN cycle
        issue(2'b01, 32'd100, 32'd7);
        cyc(); cyc(); cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_hi", 64'(hi), 64'hDEAD_BEEF);
        chk("flush_lo", 64'(lo), 64'h1234_5678);
        issue(2'b00, 32'd3, 32'd5);
        wait_idle(nb);
        chk("mul35_lo", 64'(lo), 64'd15);
        chk("mul35_hi", 64'(hi), 64'd0);

        // Flush in IDLE blocks MTHI
        flush = 1'b1;
        issue(2'b10, 32'h5555_AAAA, 32'd0);
        flush = 1'b0;
        chk("flush_idle_hi", 64'(hi), 64'd0);

        // Reset in the middle of a DIV
        issue(2'b01, 32'd1000, 32'd3);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_alu_s", 64'(alu_s), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(2'b00, 32'd6, 32'd7);
        wait_idle(nb);
        chk("post_rst_lo", 64'(lo), 64'd42);

`ifdef ALU_MULDIV_DIV0_TRAP_EN
        issue(2'b01, 32'd5, 32'd0);
        chk("div0_flag", 64'(div0), 64'd1);
        chk("div0_done", 64'(done), 64'd1);
        chk("div0_busy", 64'(busy), 64'd0);
        chk("div0_lo", 64'(lo), 64'd42);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_op    = 2'($urandom_range(0, 3));
            req_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 3))
                0: req_b = 32'd0;
                1: req_b = 32'($urandom_range(1, 20));
                default: req_b = $urandom;
            endcase
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        req_valid = 1'b0;
        flush = 1'b0;
        wait_idle(nb);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
